// File: rtl/instruction_issue_pkg.sv
// Shared types for the ID->IX boundary: decode bundle in, dispatch bundle out.
package instruction_issue_pkg;
  localparam int DATA_W    = 32;
  localparam int REG_WIDTH = 5;
  localparam int NUM_REGS  = 32;
  localparam int NUM_PIPES = 4;

  localparam int EXE_PIPE_ID_ALU = 0;
  localparam int EXE_PIPE_ID_MUL = 1;
  localparam int EXE_PIPE_ID_DIV = 2;
  localparam int EXE_PIPE_ID_LSU = 3;

  // one bit per execution pipe, indexed by EXE_PIPE_ID_*
  typedef logic [NUM_PIPES-1:0] exe_pipe_e;

  typedef struct packed {
    logic       register_write;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic [2:0] branch_op;
    logic [1:0] result_src;
    logic       mem_store;
    logic       mem_load;
    logic       icache_invalidate;
    logic [3:0] alu_control;
    logic [1:0] mul_control;
    logic [1:0] div_control;
    logic [2:0] lsu_control;
    logic       alu_src;
  } ctrl_t;

  typedef struct packed {
    logic [REG_WIDTH-1:0] a1;
    logic [REG_WIDTH-1:0] a2;
    logic [REG_WIDTH-1:0] rd;
    logic [DATA_W-1:0]    imm_ext;
    logic [DATA_W-1:0]    pc;
    logic [DATA_W-1:0]    pc_inc;
    ctrl_t                ctrl;
    exe_pipe_e            exe_pipe;
  } id_ix_inf_t;

  // control fields trail in ctrl_t order so a ctrl_t can be concatenated in
  typedef struct packed {
    logic [DATA_W-1:0]    rs1_data;
    logic [DATA_W-1:0]    rs2_data;
    logic [REG_WIDTH-1:0] rd;
    logic [DATA_W-1:0]    imm_ext;
    logic [DATA_W-1:0]    pc;
    logic [DATA_W-1:0]    pc_inc;
    logic                 register_write;
    logic                 branch;
    logic                 jal;
    logic                 jalr;
    logic [2:0]           branch_op;
    logic [1:0]           result_src;
    logic                 mem_store;
    logic                 mem_load;
    logic                 icache_invalidate;
    logic [3:0]           alu_control;
    logic [1:0]           mul_control;
    logic [1:0]           div_control;
    logic [2:0]           lsu_control;
    logic                 alu_src;
  } ix_ex_inf_t;
endpackage

// File: rtl/instruction_issue_register_file.sv
// 32-entry integer register file: two async reads, one sync write, x0 reads 0.
module instruction_issue_register_file
  import instruction_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic [REG_WIDTH-1:0] ra1,
  input  logic [REG_WIDTH-1:0] ra2,
  output logic [XLEN-1:0]      rd1,
  output logic [XLEN-1:0]      rd2,
  input  logic                 we,
  input  logic [REG_WIDTH-1:0] wa,
  input  logic [XLEN-1:0]      wd
);
  logic [XLEN-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (we && wa != '0) mem[wa] <= wd;
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];
endmodule

// File: rtl/instruction_issue.sv
// Issue stage: scoreboard hazard check, operand read with writeback bypass,
// one-hot dispatch to a single execution pipe per cycle.
module instruction_issue
  import instruction_issue_pkg::*;
#(
  parameter int XLEN      = DATA_W,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_do_branch,
  input  logic                 id_valid,
  input  id_ix_inf_t           id_ix_inf,
  output logic                 ix_stall,
  input  exe_pipe_e            exe_ready,
  input  logic                 wb_valid,
  input  logic                 wb_write,
  input  logic [REG_WIDTH-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_result,
  output exe_pipe_e            ix_valid,
  output ix_ex_inf_t           ix_ex_inf
);
  logic [NUM_REGS-1:0] pend, pend_n, wb_hit, eff;
  logic [XLEN-1:0]     rf1, rf2, rs1, rs2;
  logic                raw, waw, strct, live, fire, rf_we;

  assign rf_we = wb_valid & wb_write;

  instruction_issue_register_file #(.XLEN(XLEN)) u_rf (
    .clk (clk),
    .ra1 (id_ix_inf.a1),
    .ra2 (id_ix_inf.a2),
    .rd1 (rf1),
    .rd2 (rf2),
    .we  (rf_we),
    .wa  (wb_rd),
    .wd  (wb_result)
  );

  // a completing writeback releases its entry in the same cycle when bypassing
  always_comb begin
    wb_hit = '0;
    if (WB_BYPASS && wb_valid) wb_hit[wb_rd] = 1'b1;
  end
  assign eff = pend & ~wb_hit;

  assign raw   = eff[id_ix_inf.a1] | eff[id_ix_inf.a2];
  assign waw   = id_ix_inf.ctrl.register_write & eff[id_ix_inf.rd];
  assign strct = ~|(id_ix_inf.exe_pipe & exe_ready);
  assign live  = id_valid & ~wb_do_branch & (|id_ix_inf.exe_pipe);

  assign ix_stall = live & (raw | waw | strct);
  assign fire     = live & ~(raw | waw | strct);

  // x0 writebacks never reach the file, so they must not be forwarded either
  always_comb begin
    rs1 = rf1;
    rs2 = rf2;
    if (WB_BYPASS && rf_we && wb_rd != '0) begin
      if (wb_rd == id_ix_inf.a1) rs1 = wb_result;
      if (wb_rd == id_ix_inf.a2) rs2 = wb_result;
    end
  end

  // clear before set: a newer writer of the same rd keeps the bit
  always_comb begin
    pend_n = pend;
    if (wb_valid) pend_n[wb_rd] = 1'b0;
    if (fire && id_ix_inf.ctrl.register_write) pend_n[id_ix_inf.rd] = 1'b1;
    pend_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      ix_valid  <= '0;
      ix_ex_inf <= '0;
    end else begin
      pend     <= pend_n;
      ix_valid <= fire ? id_ix_inf.exe_pipe : '0;
      if (fire)
        ix_ex_inf <= {rs1, rs2, id_ix_inf.rd, id_ix_inf.imm_ext, id_ix_inf.pc,
                      id_ix_inf.pc_inc, id_ix_inf.ctrl};
    end
  end
endmodule
